// File: rtl/mem_stage_unit_if.sv
// Data-memory request/acknowledge bundle between the MEM stage and data memory.
// master: the MEM stage issuing requests; slave: the memory answering them.
interface mem_stage_unit_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, output we, output addr, output wdata,
                  input rdata, input ack);
  modport slave  (input req, input we, input addr, input wdata,
                  output rdata, output ack);
endinterface

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM-stage consumer of the EX/MEM register.
// - Resolves branch/jump into a PC redirect plus IF/ID/EX flush strobes.
// - Runs the data-memory req/ack handshake with a wait-state timeout,
//   stalls the pipeline while waiting and feeds the MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses are not
// issued and raise mem_error instead).
module mem_stage_unit #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              Branch_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              Jump_in,
  input  logic              ALU_zero_in,
  input  logic [DATA_W-1:0] jump_addr_in,
  input  logic [DATA_W-1:0] branch_addr_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] reg_read_data_2_in,
  input  logic [4:0]        EX_MEM_RegisterRd_in,
  mem_stage_unit_if.master  dmem,
  output logic              mem_stall,
  output logic              mem_error,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic              IF_Flush,
  output logic              ID_Flush,
  output logic              EX_Flush,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] mem_read_data_out,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic [4:0]        MEM_WB_RegisterRd_out
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_mem_op;
  logic             w_align_err;
  logic             w_req;
  logic             w_timeout_hit;
  logic             w_stall;
  logic             w_rd_done;
  logic             w_taken;

  assign w_mem_op = MemRead_in | MemWrite_in;

  // A misaligned access can only be seen when a new instruction arrives,
  // because the EX/MEM register is frozen while we wait.
`ifdef MEM_ALIGN_CHECK_EN
  assign w_align_err = w_mem_op & (ALU_result_in[1:0] != 2'b00) & (r_state == ST_IDLE);
`else
  assign w_align_err = 1'b0;
`endif

  // Handshake FSM: next state, wait counter and raw request/timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_req         = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req = w_mem_op & ~w_align_err;
        if (w_req & ~dmem.ack) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      ST_WAIT: begin
        // Timeout wins: the request is withdrawn so a late ack is ignored.
        if (r_cnt == TIMEOUT_VAL) begin
          w_req         = 1'b0;
          w_timeout_hit = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = CNT_ZERO;
        end else if (dmem.ack) begin
          w_req       = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_req       = 1'b1;
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Control outputs are forced low while reset is asserted so an
  // in-flight request is dropped immediately.
  assign w_stall    = w_req & ~dmem.ack & reset_n;
  assign w_rd_done  = w_req & dmem.ack & MemRead_in;
  assign w_taken    = Branch_in & ALU_zero_in;

  assign dmem.req   = w_req & reset_n;
  assign dmem.we    = MemWrite_in & ~MemRead_in;
  assign dmem.addr  = ALU_result_in;
  assign dmem.wdata = reg_read_data_2_in;

  assign mem_stall  = w_stall;
  assign mem_error  = (w_timeout_hit | w_align_err) & reset_n;

  assign pc_redirect = (w_taken | Jump_in) & ~w_stall & reset_n;
  assign pc_target   = Jump_in ? jump_addr_in : branch_addr_in;
  assign IF_Flush    = pc_redirect;
  assign ID_Flush    = pc_redirect;
  assign EX_Flush    = pc_redirect;

  // MEM/WB register: bubble on stall, load otherwise; failed accesses
  // never write back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite_out          <= 1'b0;
      MemtoReg_out          <= 1'b0;
      mem_read_data_out     <= {DATA_W{1'b0}};
      ALU_result_out        <= {DATA_W{1'b0}};
      MEM_WB_RegisterRd_out <= 5'd0;
    end else if (w_stall) begin
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
    end else begin
      RegWrite_out          <= RegWrite_in & ~(w_timeout_hit & MemRead_in) & ~w_align_err;
      MemtoReg_out          <= MemtoReg_in;
      mem_read_data_out     <= w_rd_done ? dmem.rdata : {DATA_W{1'b0}};
      ALU_result_out        <= ALU_result_in;
      MEM_WB_RegisterRd_out <= EX_MEM_RegisterRd_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit with a transaction-level reference model
// (outstanding-cycle count per instruction) checked every cycle, plus
// hand-computed literal expectations for the key scenarios.
module tb_mem_stage_unit;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in;
  logic          Jump_in, ALU_zero_in;
  logic [DW-1:0] jump_addr_in, branch_addr_in, ALU_result_in, reg_read_data_2_in;
  logic [4:0]    EX_MEM_RegisterRd_in;
  logic          mem_stall, mem_error, pc_redirect, IF_Flush, ID_Flush, EX_Flush;
  logic          RegWrite_out, MemtoReg_out;
  logic [DW-1:0] pc_target, mem_read_data_out, ALU_result_out;
  logic [4:0]    MEM_WB_RegisterRd_out;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage_unit_if #(.DATA_W(DW)) u_dmem ();

  mem_stage_unit #(.DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Jump_in(Jump_in),
    .ALU_zero_in(ALU_zero_in), .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .ALU_result_in(ALU_result_in), .reg_read_data_2_in(reg_read_data_2_in),
    .EX_MEM_RegisterRd_in(EX_MEM_RegisterRd_in), .dmem(u_dmem),
    .mem_stall(mem_stall), .mem_error(mem_error), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .EX_Flush(EX_Flush),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .mem_read_data_out(mem_read_data_out), .ALU_result_out(ALU_result_out),
    .MEM_WB_RegisterRd_out(MEM_WB_RegisterRd_out)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_busy = cycles the current instruction has already spent waiting on memory.
  int            m_busy;
  logic          m_rw, m_mtr;
  logic [DW-1:0] m_rdata, m_alu;
  logic [4:0]    m_rd;

  function automatic logic f_timeout();
    return (m_busy == TO);
  endfunction

  function automatic logic f_mis();
`ifdef MEM_ALIGN_CHECK_EN
    return (MemRead_in || MemWrite_in) && (ALU_result_in[1:0] != 2'b00) && (m_busy == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic f_req();
    return reset_n && !f_timeout() && (MemRead_in || MemWrite_in) && !f_mis();
  endfunction

  function automatic logic f_stall();
    return f_req() && !u_dmem.ack;
  endfunction

  function automatic logic f_err();
    return reset_n && (f_timeout() || f_mis());
  endfunction

  function automatic logic f_redir();
    return reset_n && ((Branch_in && ALU_zero_in) || Jump_in) && !f_stall();
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  <= 0;
      m_rw    <= 1'b0;
      m_mtr   <= 1'b0;
      m_rdata <= 32'h0;
      m_alu   <= 32'h0;
      m_rd    <= 5'd0;
    end else if (f_stall()) begin
      m_busy <= m_busy + 1;
      m_rw   <= 1'b0;
      m_mtr  <= 1'b0;
    end else begin
      m_busy  <= 0;
      m_rw    <= RegWrite_in && !(f_timeout() && MemRead_in) && !f_mis();
      m_mtr   <= MemtoReg_in;
      m_rdata <= (MemRead_in && f_req() && u_dmem.ack) ? u_dmem.rdata : 32'h0;
      m_alu   <= ALU_result_in;
      m_rd    <= EX_MEM_RegisterRd_in;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check1 ("req",      u_dmem.req,   f_req());
    check1 ("we",       u_dmem.we,    MemWrite_in & ~MemRead_in);
    check32("addr",     u_dmem.addr,  ALU_result_in);
    check32("wdata",    u_dmem.wdata, reg_read_data_2_in);
    check1 ("stall",    mem_stall,    f_stall());
    check1 ("error",    mem_error,    f_err());
    check1 ("redirect", pc_redirect,  f_redir());
    check32("target",   pc_target,    Jump_in ? jump_addr_in : branch_addr_in);
    check1 ("if_flush", IF_Flush,     f_redir());
    check1 ("id_flush", ID_Flush,     f_redir());
    check1 ("ex_flush", EX_Flush,     f_redir());
    check1 ("wb_rw",    RegWrite_out, m_rw);
    check1 ("wb_mtr",   MemtoReg_out, m_mtr);
    check32("wb_rdata", mem_read_data_out, m_rdata);
    check32("wb_alu",   ALU_result_out, m_alu);
    check32("wb_rd",    {27'd0, MEM_WB_RegisterRd_out}, {27'd0, m_rd});
  end

  // ---------------- stimulus helpers ----------------
  task automatic nop();
    RegWrite_in = 1'b0; MemtoReg_in = 1'b0; Branch_in = 1'b0; Jump_in = 1'b0;
    MemRead_in = 1'b0; MemWrite_in = 1'b0; ALU_zero_in = 1'b0;
    jump_addr_in = 32'h0; branch_addr_in = 32'h0; ALU_result_in = 32'h0;
    reg_read_data_2_in = 32'h0; EX_MEM_RegisterRd_in = 5'd0;
    u_dmem.ack = 1'b0; u_dmem.rdata = 32'h0;
  endtask

  task automatic set_mem(input logic rd, input logic wr, input logic rw,
                         input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [4:0] rd_idx);
    MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw; MemtoReg_in = rd;
    ALU_result_in = addr; reg_read_data_2_in = wdata; EX_MEM_RegisterRd_in = rd_idx;
  endtask

  task automatic set_ctl(input logic br, input logic zero, input logic jmp,
                         input logic [DW-1:0] baddr, input logic [DW-1:0] jaddr);
    Branch_in = br; ALU_zero_in = zero; Jump_in = jmp;
    branch_addr_in = baddr; jump_addr_in = jaddr;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the current instruction for ncycles, acking at cycle ack_after (-1 = never).
  task automatic run_op(input int ack_after, input int ncycles,
                        output int stall_cnt, output int req_cnt,
                        output int err_cnt, output int we_cnt);
    stall_cnt = 0; req_cnt = 0; err_cnt = 0; we_cnt = 0;
    for (int k = 0; k < ncycles; k++) begin
      u_dmem.ack = (k == ack_after);
      sample();
      if (mem_stall)  stall_cnt++;
      if (u_dmem.req) req_cnt++;
      if (mem_error)  err_cnt++;
      if (u_dmem.we)  we_cnt++;
      step();
    end
  endtask

  int sc, rc, ec, wc;

  initial begin
    nop();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    sample();
    check1 ("rst_req",   u_dmem.req,   1'b0);
    check1 ("rst_stall", mem_stall,    1'b0);
    check1 ("rst_rw",    RegWrite_out, 1'b0);
    check32("rst_rdata", mem_read_data_out, 32'h0);
    step();
    reset_n = 1'b1;
    step();

    // Zero-wait load
    set_mem(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd5);
    u_dmem.ack = 1'b1; u_dmem.rdata = 32'hDEADBEEF;
    sample();
    check1("ld_stall", mem_stall,  1'b0);
    check1("ld_req",   u_dmem.req, 1'b1);
    step(); nop();
    sample();
    check32("ld_data", mem_read_data_out, 32'hDEADBEEF);
    check1 ("ld_rw",   RegWrite_out, 1'b1);
    check32("ld_rd",   {27'd0, MEM_WB_RegisterRd_out}, 32'd5);

    // Store, ack after 3 wait cycles
    step();
    set_mem(1'b0, 1'b1, 1'b0, 32'h40, 32'h12345678, 5'd0);
    run_op(3, 4, sc, rc, ec, wc);
    nop();
    check_int("st_stall_cycles", sc, 3);
    check_int("st_req_cycles",   rc, 4);
    check_int("st_we_cycles",    wc, 4);
    sample();
    check32("st_alu", ALU_result_out, 32'h40);

    // Load that never completes -> timeout
    step();
    set_mem(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 5'd7);
    u_dmem.rdata = 32'hCAFEF00D;
    run_op(-1, TO + 1, sc, rc, ec, wc);
    nop();
    check_int("to_req_cycles",   rc, 16);
    check_int("to_stall_cycles", sc, 16);
    check_int("to_err_pulses",   ec, 1);
    sample();
    check1 ("to_rw",    RegWrite_out, 1'b0);
    check32("to_rd",    {27'd0, MEM_WB_RegisterRd_out}, 32'd7);
    check32("to_rdata", mem_read_data_out, 32'h0);

    // Back to IDLE: zero-wait load afterwards
    step();
    set_mem(1'b1, 1'b0, 1'b1, 32'h84, 32'h0, 5'd8);
    u_dmem.rdata = 32'h0BADCAFE;
    run_op(0, 1, sc, rc, ec, wc);
    nop();
    check_int("after_to_stall", sc, 0);
    sample();
    check32("after_to_data", mem_read_data_out, 32'h0BADCAFE);

    // Read and write both set: read wins
    step();
    set_mem(1'b1, 1'b1, 1'b1, 32'h44, 32'h55, 5'd9);
    u_dmem.ack = 1'b1; u_dmem.rdata = 32'h00001234;
    sample();
    check1("rw_both_we", u_dmem.we, 1'b0);
    step(); nop();

    // Taken branch
    set_ctl(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    sample();
    check1 ("br_redirect", pc_redirect, 1'b1);
    check32("br_target",   pc_target,   32'h200);
    check1 ("br_ex_flush", EX_Flush,    1'b1);
    step(); nop();
    sample();
    check1("br_redirect_off", pc_redirect, 1'b0);

    // Jump wins over branch
    step();
    set_ctl(1'b1, 1'b1, 1'b1, 32'h200, 32'h300);
    sample();
    check1 ("jmp_redirect", pc_redirect, 1'b1);
    check32("jmp_target",   pc_target,   32'h300);
    step(); nop();

    // Taken branch held off while a load waits one cycle
    set_ctl(1'b1, 1'b1, 1'b0, 32'h240, 32'h0);
    set_mem(1'b1, 1'b0, 1'b1, 32'h88, 32'h0, 5'd3);
    sample();
    check1("brst_redirect", pc_redirect, 1'b0);
    check1("brst_stall",    mem_stall,   1'b1);
    step();
    u_dmem.ack = 1'b1; u_dmem.rdata = 32'hA5A5A5A5;
    sample();
    check1("brst_redirect_ack", pc_redirect, 1'b1);
    step(); nop();

    // Branch not taken
    set_ctl(1'b1, 1'b0, 1'b0, 32'h260, 32'h0);
    sample();
    check1("bnt_redirect", pc_redirect, 1'b0);
    step(); nop();

    // Misaligned load
    set_mem(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'd6);
    u_dmem.ack = 1'b1; u_dmem.rdata = 32'h11112222;
    sample();
`ifdef MEM_ALIGN_CHECK_EN
    check1("mis_req",   u_dmem.req, 1'b0);
    check1("mis_err",   mem_error,  1'b1);
    check1("mis_stall", mem_stall,  1'b0);
`else
    check1 ("mis_req",  u_dmem.req,  1'b1);
    check32("mis_addr", u_dmem.addr, 32'h102);
    check1 ("mis_err",  mem_error,   1'b0);
`endif
    step(); nop();
    sample();
`ifdef MEM_ALIGN_CHECK_EN
    check1("mis_rw", RegWrite_out, 1'b0);
`else
    check1 ("mis_rw",   RegWrite_out, 1'b1);
    check32("mis_data", mem_read_data_out, 32'h11112222);
`endif

    // Reset asserted while waiting
    step();
    set_mem(1'b1, 1'b0, 1'b1, 32'h90, 32'h0, 5'd4);
    repeat (3) begin
      sample();
      step();
    end
    #1 reset_n = 1'b0;
    #1;
    check1("rstw_req",   u_dmem.req, 1'b0);
    check1("rstw_err",   mem_error,  1'b0);
    check1("rstw_stall", mem_stall,  1'b0);
    nop();
    step(); step();
    reset_n = 1'b1;
    step();
    set_mem(1'b1, 1'b0, 1'b1, 32'h94, 32'h0, 5'd2);
    u_dmem.ack = 1'b1; u_dmem.rdata = 32'h00000077;
    sample();
    check1("rstw_idle_stall", mem_stall, 1'b0);
    step(); nop();
    sample();
    check32("rstw_idle_data", mem_read_data_out, 32'h00000077);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
